param_register_block: RTL and testbench

Parametrised register file between the Master FPGA serial link and the channel-FPGA datapath. It generalises the fixed 32x32 register bank to NUM_REGS registers of DATA_W bits, with per-register read/write or read-only attributes and per-register reset defaults. It adds address auto-increment for burst access, a registered read with valid strobe, and per-register write strobes. Shadowed registers are staged and only take effect on an explicit commit. It sits directly behind the link decoder and drives configuration buses into the ADC acquisition logic.

---
 rtl/param_register_block.sv | 208 ++++++++++++++++++++
 tb/tb_param_register_block.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/param_register_block.sv
// Parametrised configuration register file behind the serial link decoder.
// Supports RW/RO/shadowed registers, burst auto-increment, registered reads
// with a valid strobe and per-register write strobes.
module param_register_block #(
    parameter int unsigned                  NUM_REGS    = 32,
    parameter int unsigned                  DATA_W      = 32,
    parameter int unsigned                  ADDR_W      = 5,
    parameter logic [NUM_REGS-1:0]          RW_MASK     = '1,
    parameter logic [NUM_REGS-1:0]          SHADOW_MASK = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   DEFAULTS    = '0,
    parameter bit                           AUTO_INC    = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         reg_num_le,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         rd_valid,
    output logic                         illegal_reg_num,
    output logic                         access_err,
    input  logic                         err_clr,
    input  logic                         commit,
    output logic                         commit_pending,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic [NUM_REGS-1:0]          wr_strobe
);

    // Wide enough to compare any reg_num against NUM_REGS without truncation
    localparam int unsigned CMP_W = DATA_W + 10;
    // Shadowing only applies to writable registers
    localparam logic [NUM_REGS-1:0] SHADOW_EFF = SHADOW_MASK & RW_MASK;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                commit_fire_c;

    logic [DATA_W-1:0]   reg_num;
    logic                legal_c;
    logic [NUM_REGS-1:0] sel_c;
    logic                wr_ro_c;
    logic                shadow_wr_c;
    logic                err_set_c;
    logic [DATA_W-1:0]   rd_mux_c;
    logic [DATA_W-1:0]   rd_src [NUM_REGS];

    // Address decode: legal iff the full reg_num is below NUM_REGS
    assign legal_c         = (CMP_W'(reg_num) < CMP_W'(NUM_REGS));
    assign illegal_reg_num = ~legal_c;

    // One-hot register select, all zero when the number is illegal
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel_c[i] = legal_c && (reg_num[ADDR_W-1:0] == ADDR_W'(i));
        end
    end

    assign wr_ro_c     = |(sel_c & ~RW_MASK);
    assign shadow_wr_c = wr_en && (|(sel_c & SHADOW_EFF));
    assign err_set_c   = (wr_en && (~legal_c || wr_ro_c)) || (rd_en && ~legal_c);

    // Read source mux; yields zero for an illegal number
    always_comb begin
        rd_mux_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_c[i]) begin
                rd_mux_c = rd_mux_c | rd_src[i];
            end
        end
    end

    // Per-register storage, strobes and readback source
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (!RW_MASK[i]) begin : g_ro
            assign rd_src[i]                       = ro_in[i*DATA_W +: DATA_W];
            assign reg_out[i*DATA_W +: DATA_W]     = '0;
            assign wr_strobe[i]                    = 1'b0;
        end else if (SHADOW_EFF[i]) begin : g_shadow
            localparam logic [DATA_W-1:0] DEF = DEFAULTS[i*DATA_W +: DATA_W];
            logic [DATA_W-1:0] act_q;
            logic [DATA_W-1:0] stg_q;
            logic              stb_q;
            logic              unused_ro;

            // Stage writes; commit moves differing staged values to active
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    act_q <= DEF;
                    stg_q <= DEF;
                    stb_q <= 1'b0;
                end else begin
                    stb_q <= 1'b0;
                    if (wr_en && sel_c[i]) begin
                        stg_q <= rx_data;
                    end
                    if (commit_fire_c && (stg_q != act_q)) begin
                        act_q <= stg_q;
                        stb_q <= 1'b1;
                    end
                end
            end

            assign unused_ro                   = ^ro_in[i*DATA_W +: DATA_W];
            assign rd_src[i]                   = stg_q;
            assign reg_out[i*DATA_W +: DATA_W] = act_q;
            assign wr_strobe[i]                = stb_q;
        end else begin : g_rw
            localparam logic [DATA_W-1:0] DEF = DEFAULTS[i*DATA_W +: DATA_W];
            logic [DATA_W-1:0] act_q;
            logic              stb_q;
            logic              unused_ro;

            // Direct write; strobe pulses on every accepted write
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    act_q <= DEF;
                    stb_q <= 1'b0;
                end else begin
                    stb_q <= wr_en && sel_c[i];
                    if (wr_en && sel_c[i]) begin
                        act_q <= rx_data;
                    end
                end
            end

            assign unused_ro                   = ^ro_in[i*DATA_W +: DATA_W];
            assign rd_src[i]                   = act_q;
            assign reg_out[i*DATA_W +: DATA_W] = act_q;
            assign wr_strobe[i]                = stb_q;
        end
    end

    // Commit state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit next-state; a shadow write alongside commit keeps us pending
    always_comb begin
        state_d       = state_q;
        commit_fire_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (shadow_wr_c) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (commit) begin
                    commit_fire_c = 1'b1;
                    if (!shadow_wr_c) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign commit_pending = (state_q == ST_PENDING);

    // Register number: latch beats auto-increment beats hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_num <= '0;
        end else if (reg_num_le) begin
            reg_num <= rx_data;
        end else if (AUTO_INC && (rd_en || wr_en) && legal_c) begin
            if (reg_num == DATA_W'(NUM_REGS - 1)) begin
                reg_num <= '0;
            end else begin
                reg_num <= reg_num + DATA_W'(1);
            end
        end
    end

    // Registered readback, valid strobe and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data    <= '0;
            rd_valid   <= 1'b0;
            access_err <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                tx_data <= rd_mux_c;
            end
            if (err_set_c) begin
                access_err <= 1'b1;
            end else if (err_clr) begin
                access_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_register_block.sv
// Directed bench for param_register_block: RW, RO, shadow, burst and errors.
module tb_param_register_block;

    localparam int unsigned NR = 32;
    localparam int unsigned DW = 32;
    localparam logic [NR-1:0]    RW_M = ~(32'd1 << 7);
    localparam logic [NR-1:0]    SH_M = 32'd1 << 8;
    localparam logic [NR*DW-1:0] DEFS = (1024'(70000) << (2 * 32));

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DW-1:0]     rx_data;
    logic              reg_num_le;
    logic              wr_en;
    logic              rd_en;
    logic [DW-1:0]     tx_data;
    logic              rd_valid;
    logic              illegal_reg_num;
    logic              access_err;
    logic              err_clr;
    logic              commit;
    logic              commit_pending;
    logic [NR*DW-1:0]  ro_in;
    logic [NR*DW-1:0]  reg_out;
    logic [NR-1:0]     wr_strobe;

    int tests = 0;
    int fails = 0;

    param_register_block #(
        .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(5),
        .RW_MASK(RW_M), .SHADOW_MASK(SH_M), .DEFAULTS(DEFS), .AUTO_INC(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .reg_num_le(reg_num_le),
        .wr_en(wr_en), .rd_en(rd_en), .tx_data(tx_data), .rd_valid(rd_valid),
        .illegal_reg_num(illegal_reg_num), .access_err(access_err), .err_clr(err_clr),
        .commit(commit), .commit_pending(commit_pending), .ro_in(ro_in),
        .reg_out(reg_out), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic latch(input logic [31:0] n);
        rx_data    = n;
        reg_num_le = 1'b1;
        tick();
        reg_num_le = 1'b0;
    endtask

    function automatic logic [31:0] slice(input int i);
        return reg_out[i*DW +: DW];
    endfunction

    initial begin
        reset_n = 1'b0; rx_data = '0; reg_num_le = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        err_clr = 1'b0; commit = 1'b0; ro_in = '0;
        ro_in[7*DW +: DW] = 32'h0000_DEAD;
        #12;
        chk("rst_reg2",    slice(2), 32'd70000);
        chk("rst_tx",      tx_data, 32'h0);
        chk("rst_valid",   32'(rd_valid), 32'h0);
        chk("rst_err",     32'(access_err), 32'h0);
        chk("rst_pending", 32'(commit_pending), 32'h0);
        chk("rst_strobe",  wr_strobe, 32'h0);
        chk("rst_illegal", 32'(illegal_reg_num), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Read default of reg2
        latch(2);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("rd2_data",  tx_data, 32'd70000);
        chk("rd2_valid", 32'(rd_valid), 32'h1);
        tick();
        chk("rd2_valid_drop", 32'(rd_valid), 32'h0);
        chk("rd2_hold",       tx_data, 32'd70000);

        // Burst write with wrap 30 -> 31 -> 0
        latch(30);
        wr_en = 1'b1; rx_data = 32'hA; tick();
        chk("burst_r30", slice(30), 32'hA);
        chk("burst_s30", wr_strobe, 32'h4000_0000);
        rx_data = 32'hB; tick();
        chk("burst_r31", slice(31), 32'hB);
        chk("burst_s31", wr_strobe, 32'h8000_0000);
        rx_data = 32'hC; tick();
        chk("burst_r0",  slice(0), 32'hC);
        chk("burst_s0",  wr_strobe, 32'h1);
        wr_en = 1'b0; tick();
        chk("burst_s_idle", wr_strobe, 32'h0);

        // Illegal register number
        latch(32'h20);
        chk("ill_flag", 32'(illegal_reg_num), 32'h1);
        wr_en = 1'b1; rx_data = 32'h5; tick(); wr_en = 1'b0;
        chk("ill_wr_err", 32'(access_err), 32'h1);
        chk("ill_wr_r0",  slice(0), 32'hC);
        chk("ill_wr_stb", wr_strobe, 32'h0);
        err_clr = 1'b1; tick();
        chk("ill_clr", 32'(access_err), 32'h0);
        rd_en = 1'b1; tick(); rd_en = 1'b0; err_clr = 1'b0;
        chk("ill_rd_err",   32'(access_err), 32'h1);
        chk("ill_rd_data",  tx_data, 32'h0);
        chk("ill_rd_valid", 32'(rd_valid), 32'h1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ill_clr2", 32'(access_err), 32'h0);

        // Shadow register 8
        latch(8);
        wr_en = 1'b1; rx_data = 32'd14; tick(); wr_en = 1'b0;
        chk("sh_active",  slice(8), 32'h0);
        chk("sh_pending", 32'(commit_pending), 32'h1);
        chk("sh_nostb",   wr_strobe, 32'h0);
        latch(8);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("sh_rd_staged", tx_data, 32'd14);
        commit = 1'b1; tick(); commit = 1'b0;
        chk("sh_commit_val", slice(8), 32'd14);
        chk("sh_commit_stb", wr_strobe, 32'h100);
        chk("sh_commit_pend", 32'(commit_pending), 32'h0);
        commit = 1'b1; tick(); commit = 1'b0;
        chk("sh_idle_commit_stb",  wr_strobe, 32'h0);
        chk("sh_idle_commit_pend", 32'(commit_pending), 32'h0);

        // Shadow write coincident with commit
        latch(8);
        wr_en = 1'b1; rx_data = 32'd14; tick();
        latch(8);
        wr_en = 1'b1; rx_data = 32'd5; commit = 1'b1; tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("co_active",  slice(8), 32'd14);
        chk("co_pending", 32'(commit_pending), 32'h1);
        chk("co_nostb",   wr_strobe, 32'h0);
        latch(8);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("co_rd_staged", tx_data, 32'd5);
        commit = 1'b1; tick(); commit = 1'b0;
        chk("co_commit_val", slice(8), 32'd5);
        chk("co_commit_stb", wr_strobe, 32'h100);

        // Read-only register 7
        latch(7);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("ro_rd",  tx_data, 32'h0000_DEAD);
        chk("ro_out", slice(7), 32'h0);
        latch(7);
        wr_en = 1'b1; rx_data = 32'h1234; tick(); wr_en = 1'b0;
        chk("ro_wr_err", 32'(access_err), 32'h1);
        chk("ro_wr_out", slice(7), 32'h0);
        chk("ro_wr_stb", wr_strobe, 32'h0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Simultaneous read and write on reg5
        latch(5);
        wr_en = 1'b1; rx_data = 32'h55; tick(); wr_en = 1'b0;
        latch(5);
        wr_en = 1'b1; rd_en = 1'b1; rx_data = 32'h66; tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw_pre_value", tx_data, 32'h55);
        chk("rw_new_value", slice(5), 32'h66);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("rw_inc_by_one", tx_data, 32'h0);

        // Reset mid-burst
        latch(10);
        wr_en = 1'b1; rx_data = 32'h77; tick();
        chk("mb_r10", slice(10), 32'h77);
        rd_en = 1'b1; tick();
        #2;
        reset_n = 1'b0;
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        chk("mb_r10_rst",  slice(10), 32'h0);
        chk("mb_r0_rst",   slice(0), 32'h0);
        chk("mb_r2_rst",   slice(2), 32'd70000);
        chk("mb_r8_rst",   slice(8), 32'h0);
        chk("mb_tx_rst",   tx_data, 32'h0);
        chk("mb_vld_rst",  32'(rd_valid), 32'h0);
        chk("mb_stb_rst",  wr_strobe, 32'h0);
        chk("mb_pend_rst", 32'(commit_pending), 32'h0);
        chk("mb_err_rst",  32'(access_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        latch(2);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("post_rst_rd2", tx_data, 32'd70000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
